// File: rtl/mycpu_pkg.sv
// Shared writeback types: decode's write_reg_t descriptor plus the commit FSM
// states and the load-request bundle consumed by load_extract.
package mycpu_pkg;

  localparam int XLEN   = 32;
  localparam int GPR_AW = 5;

  typedef enum logic [1:0] {
    SRC_NOP = 2'd0,
    SRC_ALU = 2'd1,
    SRC_MEM = 2'd2
  } src_t;

  typedef struct packed {
    logic              valid;
    src_t              src;
    logic [XLEN-1:0]   value;
    logic [GPR_AW-1:0] dst;
  } write_reg_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } wb_state_t;

  // Encoding 3 is not a named size; consumers treat it as a word.
  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2
  } load_size_t;

  typedef struct packed {
    load_size_t size;
    logic       is_unsigned;
    logic [1:0] off;
  } load_req_t;

endpackage

// File: rtl/writeback_commit_load_extract.sv
// Combinational load-data extraction: selects the byte/half lane of the raw
// aligned word and sign- or zero-extends it to DATA_W.
module load_extract
  import mycpu_pkg::*;
#(
  parameter int DATA_W = XLEN
)(
  input  logic [DATA_W-1:0] raw,
  input  load_req_t         req,
  output logic [DATA_W-1:0] value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  function automatic logic [DATA_W-1:0] extend_byte(input logic [7:0] b, input logic zext);
    return {{(DATA_W-8){b[7] & ~zext}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] extend_half(input logic [15:0] h, input logic zext);
    return {{(DATA_W-16){h[15] & ~zext}}, h};
  endfunction

  always_comb begin
    value     = raw;
    byte_lane = raw[{req.off, 3'b000} +: 8];
    half_lane = raw[{req.off[1], 4'b0000} +: 16];
    case (req.size)
      LD_B:    value = extend_byte(byte_lane, req.is_unsigned);
      LD_H:    value = extend_half(half_lane, req.is_unsigned);
      default: value = raw;
    endcase
  end

endmodule

// File: rtl/writeback_commit.sv
// Writeback/commit stage: resolves the retiring instruction's value, drives the
// GPR write port, hazard outputs and retire. Optional WRITEBACK_DEBUG_EN adds trace ports.
module writeback_commit
  import mycpu_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int REG_AW = GPR_AW
)(
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  write_reg_t        in_wr,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_unsigned,
  input  logic [1:0]        in_ld_off,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              pend_valid,
  output logic [REG_AW-1:0] pend_dst,
  output logic              pend_is_mem,
  output logic              retire
`ifdef WRITEBACK_DEBUG_EN
  ,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [31:0]       debug_wb_rf_wdata
`endif
);

  wb_state_t         state, state_nxt;
  logic              accept;
  logic              held_valid_p1;
  logic [REG_AW-1:0] held_dst_p1;
  logic [DATA_W-1:0] held_data_p1;
  load_req_t         held_req_p1;
  logic [DATA_W-1:0] ld_value;
  logic              held_writes;

  load_extract #(.DATA_W(DATA_W)) u_load_extract (
    .raw   (mem_resp_data),
    .req   (held_req_p1),
    .value (ld_value)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE, COMMIT: begin
        in_ready = 1'b1;
        retire   = (state == COMMIT);
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = (in_wr.src == SRC_MEM) ? WAIT_MEM : COMMIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT_MEM: if (mem_resp_valid) state_nxt = COMMIT;
      default:  state_nxt = IDLE;
    endcase
  end

  // p1: descriptor captured at accept; load data overwrites the value on response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      held_valid_p1 <= 1'b0;
      held_dst_p1   <= '0;
      held_data_p1  <= '0;
      held_req_p1   <= '0;
    end else if (accept) begin
      held_valid_p1 <= in_wr.valid;
      held_dst_p1   <= in_wr.dst;
      held_req_p1   <= '{size: load_size_t'(in_ld_size), is_unsigned: in_ld_unsigned, off: in_ld_off};
      held_data_p1  <= (in_wr.src == SRC_ALU) ? in_alu : in_wr.value;
    end else if ((state == WAIT_MEM) && mem_resp_valid) begin
      held_data_p1  <= ld_value;
    end
  end

  assign held_writes = held_valid_p1 && (held_dst_p1 != '0);
  assign rf_we       = (state == COMMIT) && held_writes;
  assign rf_waddr    = held_dst_p1;
  assign rf_wdata    = held_data_p1;
  assign pend_valid  = (state != IDLE) && held_writes;
  assign pend_dst    = held_dst_p1;
  assign pend_is_mem = (state == WAIT_MEM);

`ifdef WRITEBACK_DEBUG_EN
  logic [DATA_W-1:0] held_pc_p1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     held_pc_p1 <= '0;
    else if (accept) held_pc_p1 <= in_pc;
  end

  assign debug_wb_pc       = (state == COMMIT) ? held_pc_p1 : '0;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = (state == COMMIT) ? held_dst_p1 : '0;
  assign debug_wb_rf_wdata = (state == COMMIT) ? held_data_p1 : '0;
`else
  logic unused_pc;
  assign unused_pc = ^in_pc;
`endif

endmodule

// File: tb/tb_writeback_commit.sv
// Bench for writeback_commit: directed vectors plus randomized traffic against a
// transaction-level reference model (pending load / commit-next-cycle record).
`timescale 1ns/1ps
module tb_writeback_commit;
  import mycpu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  write_reg_t  in_wr = '0;
  logic [31:0] in_alu = '0;
  logic [31:0] in_pc = '0;
  logic [1:0]  in_ld_size = '0;
  logic        in_ld_unsigned = 1'b0;
  logic [1:0]  in_ld_off = '0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pend_valid;
  logic [4:0]  pend_dst;
  logic        pend_is_mem;
  logic        retire;
`ifdef WRITEBACK_DEBUG_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  writeback_commit dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_wr          (in_wr),
    .in_alu         (in_alu),
    .in_pc          (in_pc),
    .in_ld_size     (in_ld_size),
    .in_ld_unsigned (in_ld_unsigned),
    .in_ld_off      (in_ld_off),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .pend_valid     (pend_valid),
    .pend_dst       (pend_dst),
    .pend_is_mem    (pend_is_mem),
    .retire         (retire)
`ifdef WRITEBACK_DEBUG_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: a load waiting for data, or an instruction committing now.
  bit          m_busy;
  bit          m_commit;
  bit          m_valid;
  int          m_dst;
  logic [31:0] m_data;
  logic [31:0] m_pc;
  int          m_size;
  bit          m_uns;
  int          m_off;

  function automatic logic [31:0] ref_load(input logic [31:0] raw, input int size,
                                           input bit uns, input int off);
    logic [31:0] v;
    logic [31:0] mask;
    int          sh;
    if (size == 0) begin
      sh = 8 * off;
      mask = 32'h0000_00FF;
    end else if (size == 1) begin
      sh = (off >= 2) ? 16 : 0;
      mask = 32'h0000_FFFF;
    end else begin
      return raw;
    end
    v = (raw >> sh) & mask;
    if (!uns && ((v & ((mask >> 1) + 32'd1)) != 0)) v = v | ~mask;
    return v;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_commit = 0; m_valid = 0; m_dst = 0;
    m_data = '0; m_pc = '0; m_size = 0; m_uns = 0; m_off = 0;
  endtask

  task automatic model_step();
    if (in_valid && !m_busy) begin
      m_valid = in_wr.valid;
      m_dst   = int'(in_wr.dst);
      m_pc    = in_pc;
      if (in_wr.src == SRC_MEM) begin
        m_busy = 1; m_commit = 0;
        m_size = int'(in_ld_size); m_uns = in_ld_unsigned; m_off = int'(in_ld_off);
      end else begin
        m_busy = 0; m_commit = 1;
        m_data = (in_wr.src == SRC_ALU) ? in_alu : in_wr.value;
      end
    end else if (m_busy && mem_resp_valid) begin
      m_busy = 0; m_commit = 1;
      m_data = ref_load(mem_resp_data, m_size, m_uns, m_off);
    end else begin
      m_commit = 0;
    end
  endtask

  task automatic check_outputs();
    bit we_exp;
    we_exp = m_commit && m_valid && (m_dst != 0);
    chk("in_ready", 32'(in_ready), 32'(!m_busy));
    chk("retire", 32'(retire), 32'(m_commit));
    chk("rf_we", 32'(rf_we), 32'(we_exp));
    chk("pend_valid", 32'(pend_valid), 32'((m_busy || m_commit) && m_valid && (m_dst != 0)));
    chk("pend_is_mem", 32'(pend_is_mem), 32'(m_busy));
    chk("pend_dst", 32'(pend_dst), 32'(m_dst));
    if (m_commit) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(m_dst));
      chk("rf_wdata", rf_wdata, m_data);
    end
`ifdef WRITEBACK_DEBUG_EN
    chk("dbg_pc", debug_wb_pc, m_commit ? m_pc : 32'd0);
    chk("dbg_wen", 32'(debug_wb_rf_wen), we_exp ? 32'hF : 32'h0);
    chk("dbg_wnum", 32'(debug_wb_rf_wnum), m_commit ? 32'(m_dst) : 32'd0);
    chk("dbg_wdata", debug_wb_rf_wdata, m_commit ? m_data : 32'd0);
`endif
  endtask

  // Inputs are driven at the negedge; the model advances on the posedge and
  // outputs are compared at the following negedge.
  task automatic cycle();
    @(posedge clk);
    if (!resetn) model_reset();
    else         model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input bit v, input bit wv, input int src, input int dst,
                       input logic [31:0] val, input logic [31:0] alu,
                       input int sz, input bit uns, input int off);
    in_valid       = v;
    in_wr.valid    = wv;
    in_wr.src      = src_t'(2'(src));
    in_wr.value    = val;
    in_wr.dst      = 5'(dst);
    in_alu         = alu;
    in_ld_size     = 2'(sz);
    in_ld_unsigned = uns;
    in_ld_off      = 2'(off);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 32'd0, 32'd0, 0, 0, 0);
    cycle();
  endtask

  task automatic do_load(input string tag, input int dst, input int sz, input bit uns,
                         input int off, input logic [31:0] resp, input logic [31:0] expv);
    drive(1, 1, 2, dst, $urandom, $urandom, sz, uns, off);
    cycle();
    drive(0, 0, 0, 0, 32'd0, 32'd0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk({tag, "_wait_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_wait_mem"}, 32'(pend_is_mem), 32'd1);
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = resp;
    cycle();
    mem_resp_valid = 1'b0;
    chk({tag, "_we"}, 32'(rf_we), 32'd1);
    chk({tag, "_waddr"}, 32'(rf_waddr), 32'(dst));
    chk({tag, "_data"}, rf_wdata, expv);
    idle();
  endtask

  initial begin
    model_reset();
    resetn = 1'b0;
    repeat (2) cycle();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    resetn = 1'b1;
    idle();

    // ADDU into r8
    drive(1, 1, 1, 8, 32'd0, 32'h0000_1234, 2, 0, 0);
    cycle();
    chk("addu_we", 32'(rf_we), 32'd1);
    chk("addu_waddr", 32'(rf_waddr), 32'd8);
    chk("addu_wdata", rf_wdata, 32'h0000_1234);
    chk("addu_retire", 32'(retire), 32'd1);
    idle();

    // Three back-to-back carried-value writes
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 2 + i, 32'h100 + 32'(i), $urandom, 2, 0, 0);
      cycle();
      chk("nop_we", 32'(rf_we), 32'd1);
      chk("nop_waddr", 32'(rf_waddr), 32'(2 + i));
      chk("nop_ready", 32'(in_ready), 32'd1);
    end
    idle();

    do_load("lb", 9, 0, 0, 3, 32'h80FF_FFFF, 32'hFFFF_FF80);
    do_load("lbu", 9, 0, 1, 3, 32'h80FF_FFFF, 32'h0000_0080);
    do_load("lhu", 10, 1, 1, 2, 32'hBEEF_0000, 32'h0000_BEEF);

    // dst==0 and a non-writing store still retire
    drive(1, 1, 1, 0, 32'd0, 32'hDEAD_BEEF, 2, 0, 0);
    cycle();
    chk("r0_retire", 32'(retire), 32'd1);
    chk("r0_we", 32'(rf_we), 32'd0);
    chk("r0_pend", 32'(pend_valid), 32'd0);
    drive(1, 0, 0, 5, 32'h1111_2222, 32'd0, 2, 0, 0);
    cycle();
    chk("sw_retire", 32'(retire), 32'd1);
    chk("sw_we", 32'(rf_we), 32'd0);
    chk("sw_pend", 32'(pend_valid), 32'd0);
    idle();

    // Reset during WAIT_MEM, then a stale response
    drive(1, 1, 2, 7, 32'd0, 32'd0, 2, 0, 0);
    cycle();
    idle();
    chk("rstw_mem", 32'(pend_is_mem), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rstw_async_ready", 32'(in_ready), 32'd1);
    chk("rstw_async_mem", 32'(pend_is_mem), 32'd0);
    cycle();
    resetn = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1234_5678;
    cycle();
    mem_resp_valid = 1'b0;
    chk("late_we", 32'(rf_we), 32'd0);
    chk("late_retire", 32'(retire), 32'd0);
    chk("late_ready", 32'(in_ready), 32'd1);
    idle();

`ifdef WRITEBACK_DEBUG_EN
    drive(1, 1, 1, 31, 32'd0, 32'hBFC0_0018, 2, 0, 0);
    in_pc = 32'hBFC0_0010;
    cycle();
    chk("jal_pc", debug_wb_pc, 32'hBFC0_0010);
    chk("jal_wen", 32'(debug_wb_rf_wen), 32'hF);
    chk("jal_wnum", 32'(debug_wb_rf_wnum), 32'd31);
    chk("jal_wdata", debug_wb_rf_wdata, 32'hBFC0_0018);
    idle();
`endif

    // Randomized traffic, including stray responses and occasional resets
    for (int n = 0; n < 600; n++) begin
      resetn = ($urandom_range(0, 59) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, int'($urandom_range(0, 2)),
            ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 31)),
            $urandom, $urandom, int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 3)));
      in_pc          = $urandom;
      mem_resp_valid = ($urandom_range(0, 2) == 0);
      mem_resp_data  = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_commit.md
Name: writeback_commit

Overview:
Consumer end of the write_reg_t descriptor produced at decode. It accepts one retiring instruction per handshake and resolves the final register value:
- SRC_NOP uses the carried value.
- SRC_ALU uses the ALU result.
- SRC_MEM uses the extracted load data.
It then drives the single GPR write port, forwarding/hazard outputs and a retire pulse. It sits between the memory stage and the register file.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, GPR address width

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
in_valid  in  1  descriptor offered by memory stage
in_ready  out  1  block can accept this cycle
in_wr  in  write_reg_t  {valid, src, value, dst} from decode
in_alu  in  DATA_W  ALU result for this instruction
in_pc  in  DATA_W  instruction PC
in_ld_size  in  2  0=byte, 1=half, 2=word
in_ld_unsigned  in  1  zero-extend load
in_ld_off  in  2  address bits [1:0]
mem_resp_valid  in  1  load data returned
mem_resp_data  in  DATA_W  raw aligned word
rf_we  out  1  GPR write enable
rf_waddr  out  REG_AW  GPR write index
rf_wdata  out  DATA_W  GPR write data
pend_valid  out  1  write accepted, not yet committed
pend_dst  out  REG_AW  its destination
pend_is_mem  out  1  pending write awaits load data (stall, no forward)
retire  out  1  one-cycle pulse per completed instruction

Behaviour:
- States:
  - IDLE: nothing held.
  - WAIT_MEM: load accepted, no response yet.
  - COMMIT: value held in output register.
- in_ready = (state==IDLE) || (state==COMMIT).
- Accept = in_valid && in_ready.
- Transitions:
  - IDLE: accept with src==SRC_MEM -> WAIT_MEM; other accept -> COMMIT; no accept -> stay.
  - WAIT_MEM: mem_resp_valid -> COMMIT; otherwise hold. in_ready=0 throughout.
  - COMMIT: outputs valid this cycle. Same-cycle accept follows the IDLE rules; otherwise -> IDLE.
- Latency:
  - Non-load: rf_we is high exactly 1 cycle after accept.
  - Load: rf_we is high 1 cycle after mem_resp_valid (response may arrive the cycle after accept at earliest).
- Back-to-back non-loads sustain 1 instruction/cycle.
- In COMMIT:
  - retire=1.
  - rf_we = held.valid && held.dst!=0.
  - rf_waddr = held.dst; rf_wdata = resolved value.
- rf_we is never asserted outside COMMIT.
- wr.valid=0 or dst==0: instruction still accepted and retires; no GPR write.
- Load extraction:
  - Byte lane = in_ld_off; half lane = in_ld_off[1]; word ignores offset.
  - Sign- or zero-extension per in_ld_unsigned.
  - Misalignment is checked upstream, not here.
  - in_ld_size==3 is treated as word.
- mem_resp_valid outside WAIT_MEM is ignored (no state change, no write).
- Hazard outputs:
  - pend_valid = (state!=IDLE) && held.valid && held.dst!=0.
  - pend_is_mem = (state==WAIT_MEM).
  - pend_dst = held.dst.
- Reset (asynchronous, any state, including mid-WAIT_MEM): state=IDLE, held descriptor cleared, in-flight load dropped. A late response after reset is ignored.
- Reset values: in_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, pend_valid=0, pend_dst=0, pend_is_mem=0, retire=0.

Optional Feature:
WRITEBACK_DEBUG_EN:
- Defined: adds outputs debug_wb_pc (32), debug_wb_rf_wen (4), debug_wb_rf_wnum (5), debug_wb_rf_wdata (32), all registered with COMMIT.
  - debug_wb_rf_wen = {4{rf_we}}; debug_wb_pc = held PC.
  - All are 0 at reset and whenever not in COMMIT.
- Undefined: ports absent and in_pc is unused (not stored).

Decomposition:
- mycpu package: wb_state_t enum (IDLE, WAIT_MEM, COMMIT); load_size_t (LD_B, LD_H, LD_W); load_req_t bundle {size, unsigned, off}.
- write_reg_t and src_t are reused unchanged.
- One sub-module: load_extract (combinational raw word + load_req_t -> extended value), instantiated once.

Test Plan:
- Reset then ADDU descriptor {valid=1, SRC_ALU, dst=8}, in_alu=0x1234 -> next cycle rf_we=1, waddr=8, wdata=0x1234, retire=1.
- Three back-to-back SRC_NOP writes to regs 2, 3, 4 -> rf_we on 3 consecutive cycles, in_ready held 1.
- LB dst=9, off=3, resp 0x80FFFFFF delivered 4 cycles after accept -> in_ready=0 and pend_is_mem=1 during the wait; then wdata=0xFFFFFF80. Same with LBU -> 0x00000080. LHU off=2, resp 0xBEEF0000 -> 0x0000BEEF.
- Descriptors with dst=0 and with valid=0 (SW) -> retire=1, rf_we=0, pend_valid=0.
- Assert resetn=0 while in WAIT_MEM, release, then pulse mem_resp_valid -> no rf_we, state IDLE, in_ready=1.
- With WRITEBACK_DEBUG_EN: JAL {dst=31}, pc=0xBFC00010, in_alu=0xBFC00018 -> debug_wb_pc=0xBFC00010, wen=4'hF, wnum=31, wdata=0xBFC00018.
